mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Core-side initiator for the unified 64K x 32 RAM; sits between the processor datapath and the RAM.
//  Accepts single-word load/store requests over a valid/ready handshake and sequences the RAM data port.
//  RAM port contract: ram_rw=1 enables the access; ram_data_out is valid only while ram_rw=1.
//  A write commits when ram_data_in changes while ram_rw=1.
//  Also runs an independent 2-cycle instruction fetch path on the RAM fetch port.
// PARAMETERS
//  ADDR_W  16  data address width (RAM depth 2^ADDR_W)
//  DATA_W  32  word width
//  PC_W    8   fetch address width
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  req_valid     in   1       core request valid
//  req_ready     out  1       unit idle, request accepted on valid&ready
//  req_we        in   1       1=store, 0=load
//  req_addr      in   ADDR_W  word address
//  req_wdata     in   DATA_W  store data
//  resp_valid    out  1       1-cycle completion pulse (load and store)
//  resp_rdata    out  DATA_W  load data; held until next load completes
//  ram_rw        out  1       RAM access enable
//  ram_address   out  ADDR_W  RAM data address
//  ram_data_in   out  DATA_W  RAM write data
//  ram_data_out  in   DATA_W  RAM read data (combinational)
//  fetch_en      in   1       start fetch of pc_in
//  pc_in         in   PC_W    program counter from core
//  ram_pc_addr   out  PC_W    RAM fetch address
//  ram_fetch_in  in   DATA_W  RAM fetch data (combinational)
//  instr_out     out  DATA_W  fetched instruction, held
//  instr_valid   out  1       1-cycle pulse when instr_out updates
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; ram_rw=0; ram_address=0; ram_data_in=0.
//    resp_valid=0; resp_rdata=0; ram_pc_addr=0; instr_out=0; instr_valid=0.
//  - All outputs are registered; req_ready=1 only in IDLE.
//  - FSM states: IDLE, SETUP, READ, ARM, COMMIT, HOLD, RESP.
//  - IDLE: on valid&ready, latch addr/we/wdata and go to SETUP. Requests outside IDLE are ignored (not queued).
//  - SETUP: ram_address=addr, ram_rw=0.
//    Store: ram_data_in=~wdata. Load: ram_data_in unchanged.
//    Next state: store -> ARM, load -> READ.
//  - READ: ram_rw=1, ram_data_in unchanged (no write event).
//    At the closing edge: resp_rdata<=ram_data_out; go to RESP.
//  - ARM: ram_rw=1, ram_data_in still ~wdata (no change, so no write).
//  - COMMIT: ram_data_in=wdata with ram_rw=1. This is the only write event.
//  - HOLD: ram_rw=1; address and data stable for one cycle.
//  - RESP: ram_rw=0; resp_valid=1 for exactly 1 cycle; next state IDLE.
//  - Latency counts edges after the accept edge, to the cycle in which resp_valid=1.
//    Load = 3 (SETUP, READ, RESP). Store = 5 (SETUP, ARM, COMMIT, HOLD, RESP).
//  - Store leaves resp_rdata unchanged.
//  - Invariants:
//    - ram_data_in changes only in SETUP (rw=0) or COMMIT.
//    - ram_address is never changed while ram_rw=1.
//  - Back-to-back: the next accept is earliest at the edge ending RESP's following IDLE cycle.
//  - Boundary: addr 0 and 2^ADDR_W-1 are both legal (no wrap logic). wdata==~wdata is impossible, so a store always produces a change.
//  - Fetch path (independent of FSM):
//    - fetch_en at edge N: ram_pc_addr<=pc_in.
//    - Edge N+1: instr_out<=ram_fetch_in, instr_valid=1 for one cycle.
//    - fetch_en on consecutive cycles pipelines: one result per cycle, in order.
//  - Reset mid-transaction: FSM aborts to IDLE and ram_rw drops immediately.
//    A store aborted before COMMIT leaves RAM unmodified. No resp_valid is issued for the aborted request.
// TESTING
//  1. Store addr=0x0010 data=0xDEADBEEF -> resp_valid 5 edges after accept; exactly one write event, during COMMIT, with rw=1. Load 0x0010 -> resp_rdata=0xDEADBEEF, 3 edges after accept.
//  2. Store of the same value 0x00000000 twice to 0xFFFF -> both commit (ram_data_in toggles ~d->d). Load 0xFFFF -> 0x00000000.
//  3. Hold req_valid=1 continuously with changing addr -> only the addr latched at each accept is used; req_ready=0 during SETUP..RESP.
//  4. Load then store back-to-back -> ram_address is never changed while ram_rw=1; no spurious write during load (data_in constant in READ).
//  5. Assert rst_n=0 during ARM of a store to 0x0020 (old 0x12345678) -> ram_rw=0 at once; no resp_valid; subsequent load returns 0x12345678.
//  6. fetch_en on 3 cycles, pc_in=0x00,0x01,0x02, with RAM holding 0xA,0xB,0xC -> instr_valid on 3 consecutive cycles, instr_out=0xA,0xB,0xC, concurrent with an active store.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Core-side request/response channel of the memory access unit.
// The core drives the request and the unit drives ready and the response.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Core-side initiator for the unified RAM. Sequences single-word loads and
// stores on the RAM data port, where a write commits on a change of
// ram_data_in while ram_rw is high. A store therefore parks ~wdata on the
// bus first and then flips to wdata. This is always a real change, even
// when the same value is stored twice. An independent 2-cycle fetch path
// drives the RAM fetch port.
//
// All outputs are registered from the current state, so the bus view of a
// state appears one cycle after the FSM enters it. Load responds 3 edges
// after accept and store responds 5 edges after accept.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              fetch_en,
  input  logic [PC_W-1:0]   pc_in,
  output logic [PC_W-1:0]   ram_pc_addr,
  input  logic [DATA_W-1:0] ram_fetch_in,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid
);

  typedef enum logic [2:0] {IDLE, SETUP, READ, ARM, COMMIT, HOLD, RESP} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [1:0]        vld_pipe;

  assign accept      = bus.req_valid && bus.req_ready;
  assign instr_valid = vld_pipe[1];

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing: load SETUP-READ-RESP, store SETUP-ARM-COMMIT-HOLD-RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = op_we ? ARM : READ;
      READ:    state_nxt = RESP;
      ARM:     state_nxt = COMMIT;
      COMMIT:  state_nxt = HOLD;
      HOLD:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request at accept; later requests are ignored until idle again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (accept) begin
      op_we    <= bus.req_we;
      op_addr  <= bus.req_addr;
      op_wdata <= bus.req_wdata;
    end
  end

  // Registered RAM data port and response outputs, driven from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      ram_rw         <= 1'b0;
      ram_address    <= '0;
      ram_data_in    <= '0;
    end else begin
      bus.req_ready  <= (state == IDLE) && !accept;
      bus.resp_valid <= 1'b0;
      case (state)
        SETUP: begin
          // Address and the inverted store data settle while rw is low.
          ram_rw      <= 1'b0;
          ram_address <= op_addr;
          if (op_we) ram_data_in <= ~op_wdata;
        end
        READ, ARM, HOLD: ram_rw <= 1'b1;
        COMMIT: begin
          // The single data change under rw=1 is the write event.
          ram_rw      <= 1'b1;
          ram_data_in <= op_wdata;
        end
        RESP: begin
          // rw is still high on the bus here for a load, so data_out is valid.
          ram_rw         <= 1'b0;
          bus.resp_valid <= 1'b1;
          if (!op_we) bus.resp_rdata <= ram_data_out;
        end
        default: ram_rw <= 1'b0;
      endcase
    end
  end

  // Fetch pipeline: address at the request edge, instruction one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      ram_pc_addr <= '0;
      instr_out   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], fetch_en};
      if (fetch_en)    ram_pc_addr <= pc_in;
      if (vld_pipe[0]) instr_out   <= ram_fetch_in;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit. A RAM model commits writes on a data change
// under rw=1. A transaction-level reference (latency, memory contents,
// fetch delay) is checked every cycle, and directed scenarios carry
// hand-computed literal expectations.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_rw;
  logic [15:0] ram_address;
  logic [31:0] ram_data_in, ram_data_out;
  logic        fetch_en = 1'b0;
  logic [7:0]  pc_in = '0;
  logic [7:0]  ram_pc_addr;
  logic [31:0] ram_fetch_in, instr_out;
  logic        instr_valid;

  mem_access_unit_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(16), .DATA_W(32), .PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_rw(ram_rw), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .fetch_en(fetch_en), .pc_in(pc_in),
    .ram_pc_addr(ram_pc_addr), .ram_fetch_in(ram_fetch_in),
    .instr_out(instr_out), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];
  assign ram_data_out = mem[ram_address];
  assign ram_fetch_in = mem[{8'h00, ram_pc_addr}];

  int checks = 0;
  int failures = 0;
  int write_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout", name);
  endtask

  // Reference model state
  int          cyc = 0;
  bit          pend = 0;
  bit          pend_we;
  logic [15:0] pend_addr;
  logic [31:0] pend_wdata;
  int          due = 0;
  int          ready_at = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_instr = '0;
  logic        fe_d1 = 0, fe_d2 = 0;
  logic [7:0]  pc_d1 = '0, pc_d2 = '0;
  logic        prev_rw = 0;
  logic [15:0] prev_addr = '0;
  logic [31:0] prev_din = '0;

  // RAM model plus per-cycle comparison against the transaction-level reference.
  always @(negedge clk) begin
    logic wrote, exp_valid, exp_commit, exp_ready;
    cyc++;
    if (!rst_n) begin
      chk("rst_rw", 32'(ram_rw), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_address", 32'(ram_address), 32'd0);
      chk("rst_data_in", ram_data_in, 32'd0);
      pend = 0; exp_rdata = '0; exp_instr = '0; ready_at = 0;
      fe_d1 = 0; fe_d2 = 0;
      prev_rw = 0; prev_addr = '0; prev_din = '0;
    end else begin
      wrote = ram_rw && (ram_data_in != prev_din);
      if (wrote) begin
        mem[ram_address] = ram_data_in;
        write_cnt++;
      end
      if (ram_rw) chk("addr_stable_rw", 32'(ram_address), 32'(prev_addr));
      exp_commit = pend && pend_we && (cyc == due - 2);
      chk("write_event", 32'(wrote), 32'(exp_commit));

      exp_valid = pend && (cyc == due);
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
      if (exp_valid) begin
        if (pend_we) ref_mem[pend_addr] = pend_wdata;
        else         exp_rdata = ref_mem[pend_addr];
        pend = 0;
      end
      chk("resp_rdata", bus.resp_rdata, exp_rdata);

      exp_ready = !pend && (cyc >= ready_at);
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      if (bus.req_valid && exp_ready) begin
        pend = 1; pend_we = bus.req_we;
        pend_addr = bus.req_addr; pend_wdata = bus.req_wdata;
        due = cyc + 1 + (bus.req_we ? 5 : 3);
        ready_at = due + 1;
      end

      chk("instr_valid", 32'(instr_valid), 32'(fe_d2));
      if (fe_d2) exp_instr = mem[{8'h00, pc_d2}];
      chk("instr_out", instr_out, exp_instr);
      fe_d2 = fe_d1; pc_d2 = pc_d1;
      fe_d1 = fetch_en; pc_d1 = pc_in;

      prev_rw = ram_rw; prev_addr = ram_address; prev_din = ram_data_in;
    end
  end

  task automatic wait_accept(input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_req(input string name, input logic we, input logic [15:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd);
    bus.req_we = we; bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    wait_accept(name);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.resp_valid) break;
    end
    if (!bus.resp_valid) timeout(name);
    rd = bus.resp_rdata;
  endtask

  initial begin
    int lat, w0;
    logic [31:0] rd;
    logic [31:0] lit [3];
    lit = '{32'h0000000A, 32'h0000000B, 32'h0000000C};
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC;
    ref_mem[0] = 32'hA; ref_mem[1] = 32'hB; ref_mem[2] = 32'hC;
    mem[16'h0020] = 32'h12345678; ref_mem[16'h0020] = 32'h12345678;
    mem[16'hFFFF] = 32'hCAFEF00D; ref_mem[16'hFFFF] = 32'hCAFEF00D;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", bus.resp_rdata, 32'd0);
    chk("reset_instr", instr_out, 32'd0);
    chk("reset_pc_addr", 32'(ram_pc_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: store then load at 0x0010
    w0 = write_cnt;
    run_req("t1_store", 1'b1, 16'h0010, 32'hDEADBEEF, lat, rd);
    chk("t1_store_lat", 32'(lat), 32'd5);
    chk("t1_writes", 32'(write_cnt - w0), 32'd1);
    chk("t1_mem", mem[16'h0010], 32'hDEADBEEF);
    chk("t1_store_keeps_rdata", rd, 32'd0);
    run_req("t1_load", 1'b0, 16'h0010, 32'h0, lat, rd);
    chk("t1_load_lat", 32'(lat), 32'd3);
    chk("t1_load_data", rd, 32'hDEADBEEF);

    // 2: same value twice to the top address, both must commit
    for (int k = 0; k < 2; k++) begin
      w0 = write_cnt;
      run_req("t2_store", 1'b1, 16'hFFFF, 32'h00000000, lat, rd);
      chk("t2_writes", 32'(write_cnt - w0), 32'd1);
    end
    run_req("t2_load", 1'b0, 16'hFFFF, 32'h0, lat, rd);
    chk("t2_load_data", rd, 32'h00000000);

    // 3: valid held high with a changing address
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bus.req_addr = 16'h001E + 16'(i);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 4: load then store back to back
    run_req("t4_load", 1'b0, 16'hFFFF, 32'h0, lat, rd);
    chk("t4_load_data", rd, 32'h00000000);
    run_req("t4_store", 1'b1, 16'hFFFE, 32'h0BADF00D, lat, rd);
    chk("t4_store_lat", 32'(lat), 32'd5);
    chk("t4_mem", mem[16'hFFFE], 32'h0BADF00D);

    // 5: reset during ARM of a store to 0x0020
    @(posedge clk); #1;
    bus.req_we = 1'b1; bus.req_addr = 16'h0020; bus.req_wdata = 32'h11111111;
    bus.req_valid = 1'b1;
    wait_accept("t5_accept");
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_arm_rw", 32'(ram_rw), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rw_drop", 32'(ram_rw), 32'd0);
    chk("t5_no_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_mem_intact", mem[16'h0020], 32'h12345678);
    run_req("t5_load", 1'b0, 16'h0020, 32'h0, lat, rd);
    chk("t5_load_lat", 32'(lat), 32'd3);
    chk("t5_load_data", rd, 32'h12345678);

    // 6: three back-to-back fetches while a store is active
    @(posedge clk); #1;
    bus.req_we = 1'b1; bus.req_addr = 16'h0100; bus.req_wdata = 32'h55AA55AA;
    bus.req_valid = 1'b1;
    wait_accept("t6_accept");
    fetch_en = 1'b1; pc_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i >= 1) begin
        chk("t6_instr_valid", 32'(instr_valid), 32'd1);
        chk("t6_instr_out", instr_out, lit[i-1]);
      end
      if (i < 2) pc_in = 8'(i + 1);
      else fetch_en = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    chk("t6_mem", mem[16'h0100], 32'h55AA55AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
